// File: rtl/aibcr3aux_osc_dly_ctrl_pkg.sv
// Shared types and constants for the aux oscillator delay-chain sequencer.
package aibcr3aux_osc_dly_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    READY  = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_EARLY   = 2'd2;
  localparam logic [1:0] FC_LOST    = 2'd3;

  localparam int unsigned DEF_ARM_CYC    = 2;
  localparam int unsigned DEF_MIN_DLY    = 8;
  localparam int unsigned DEF_TIMEOUT    = 32;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_CW         = 6;

  // Chain reset is released only while the chain is expected to be running.
  function automatic logic chain_released(state_t s);
    return (s == WAIT) || (s == SETTLE) || (s == READY);
  endfunction

endpackage

// File: rtl/aibcr3aux_osc_dly_ctrl_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
module aibcr3aux_osc_dly_ctrl_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aibcr3aux_osc_dly_ctrl.sv
// Aux oscillator startup sequencer: arms the delay chain, measures its
// delay against a window, settles, then enables the gated clock.
module aibcr3aux_osc_dly_ctrl
  import aibcr3aux_osc_dly_ctrl_pkg::*;
#(
  parameter int unsigned ARM_CYC    = DEF_ARM_CYC,
  parameter int unsigned MIN_DLY    = DEF_MIN_DLY,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned CW         = DEF_CW
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          osc_en,
  input  logic          fault_clr,
  input  logic          dly_q,
  output logic          dly_rstb,
  output logic          clk_gate_en,
  output logic          osc_ready,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [CW-1:0] meas_cnt,
  output logic [2:0]    state_o
);

  localparam logic [CW-1:0] ARM_LAST    = CW'(ARM_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] MIN_V       = CW'(MIN_DLY);
  localparam logic [CW-1:0] TMO_V       = CW'(TIMEOUT);

  state_t          state, nxt;
  logic [CW-1:0]   cnt, nxt_cnt, nxt_meas;
  logic [1:0]      nxt_code;
  logic            dly_q_s;

  aibcr3aux_osc_dly_ctrl_sync2 u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (dly_q),
    .q    (dly_q_s)
  );

  always_comb begin
    nxt      = state;
    nxt_cnt  = cnt;
    nxt_meas = meas_cnt;
    nxt_code = fault_code;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (osc_en) nxt = ARM;
      end
      ARM: begin
        if (!osc_en) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else if (cnt == ARM_LAST) begin
          nxt_cnt = '0;
          if (dly_q_s) begin
            nxt      = FAULT;
            nxt_code = FC_LOST;
          end else begin
            nxt = WAIT;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      // osc_en abort outranks an arriving edge, which outranks timeout.
      WAIT: begin
        if (!osc_en) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else if (dly_q_s) begin
          nxt_meas = cnt;
          nxt_cnt  = '0;
          if (cnt < MIN_V) begin
            nxt      = FAULT;
            nxt_code = FC_EARLY;
          end else begin
            nxt = SETTLE;
          end
        end else if (cnt == TMO_V) begin
          nxt      = FAULT;
          nxt_code = FC_TIMEOUT;
          nxt_meas = TMO_V;
          nxt_cnt  = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (!osc_en) begin
          nxt     = IDLE;
          nxt_cnt = '0;
        end else if (!dly_q_s) begin
          nxt      = FAULT;
          nxt_code = FC_LOST;
          nxt_cnt  = '0;
        end else if (cnt == SETTLE_LAST) begin
          nxt     = READY;
          nxt_cnt = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      READY: begin
        if (!osc_en) begin
          nxt = IDLE;
        end else if (!dly_q_s) begin
          nxt      = FAULT;
          nxt_code = FC_LOST;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          nxt      = IDLE;
          nxt_code = FC_NONE;
          nxt_cnt  = '0;
        end
      end
      default: begin
        nxt      = IDLE;
        nxt_cnt  = '0;
        nxt_code = FC_NONE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flop alongside it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      cnt         <= '0;
      meas_cnt    <= '0;
      fault_code  <= FC_NONE;
      dly_rstb    <= 1'b0;
      clk_gate_en <= 1'b0;
      osc_ready   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= nxt_cnt;
      meas_cnt    <= nxt_meas;
      fault_code  <= nxt_code;
      dly_rstb    <= chain_released(nxt);
      clk_gate_en <= (nxt == READY);
      osc_ready   <= (nxt == READY);
      fault       <= (nxt == FAULT);
    end
  end

  assign state_o = 3'(state);

endmodule

// File: tb/tb_aibcr3aux_osc_dly_ctrl.sv
// Directed scoreboard bench for the aux oscillator delay-chain sequencer.
module tb_aibcr3aux_osc_dly_ctrl;
  import aibcr3aux_osc_dly_ctrl_pkg::*;

  localparam int unsigned CW = 6;

  logic          clk = 1'b0;
  logic          rstb, osc_en, fault_clr, dly_q;
  logic          dly_rstb, clk_gate_en, osc_ready, fault;
  logic [1:0]    fault_code;
  logic [CW-1:0] meas_cnt;
  logic [2:0]    state_o;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    string         tag;
    state_t        st;
    logic [1:0]    code;
    logic [CW-1:0] meas;
  } exp_t;

  exp_t sbq[$];

  aibcr3aux_osc_dly_ctrl #(
    .ARM_CYC    (2),
    .MIN_DLY    (8),
    .TIMEOUT    (32),
    .SETTLE_CYC (4),
    .CW         (CW)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .osc_en      (osc_en),
    .fault_clr   (fault_clr),
    .dly_q       (dly_q),
    .dly_rstb    (dly_rstb),
    .clk_gate_en (clk_gate_en),
    .osc_ready   (osc_ready),
    .fault       (fault),
    .fault_code  (fault_code),
    .meas_cnt    (meas_cnt),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string tag, input string fld,
                     input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    assert (got === want) else begin
      n_mis++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, fld, got, want);
    end
  endtask

  task automatic push(input string tag, input state_t st,
                      input logic [1:0] code, input logic [CW-1:0] meas);
    exp_t e;
    e.tag = tag; e.st = st; e.code = code; e.meas = meas;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic rel, rdy;
    if (sbq.size() == 0) begin
      cmp("sb", "empty", 8'd1, 8'd0);
      return;
    end
    e   = sbq.pop_front();
    rel = (e.st == WAIT) || (e.st == SETTLE) || (e.st == READY);
    rdy = (e.st == READY);
    cmp(e.tag, "state",       8'(state_o),     8'(e.st));
    cmp(e.tag, "dly_rstb",    8'(dly_rstb),    8'(rel));
    cmp(e.tag, "clk_gate_en", 8'(clk_gate_en), 8'(rdy));
    cmp(e.tag, "osc_ready",   8'(osc_ready),   8'(rdy));
    cmp(e.tag, "fault",       8'(fault),       8'(e.st == FAULT));
    cmp(e.tag, "fault_code",  8'(fault_code),  8'(e.code));
    cmp(e.tag, "meas_cnt",    8'(meas_cnt),    8'(e.meas));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the expectation, advance n edges, then compare.
  task automatic step(input int n, input string tag, input state_t st,
                      input logic [1:0] code, input logic [CW-1:0] meas);
    push(tag, st, code, meas);
    tick(n);
    pop_check();
  endtask

  initial begin
    rstb = 1'b0; osc_en = 1'b0; fault_clr = 1'b0; dly_q = 1'b0;
    #3;
    push("rst", IDLE, FC_NONE, 6'd0);
    pop_check();
    tick(2);
    rstb = 1'b1;
    step(1, "idle", IDLE, FC_NONE, 6'd0);

    // Nominal start: edge seen at WAIT count 10
    osc_en = 1'b1;
    step(1, "n_arm0",   ARM,    FC_NONE, 6'd0);
    step(1, "n_arm1",   ARM,    FC_NONE, 6'd0);
    step(1, "n_wait",   WAIT,   FC_NONE, 6'd0);
    step(8, "n_wait8",  WAIT,   FC_NONE, 6'd0);
    dly_q = 1'b1;
    step(2, "n_wait10", WAIT,   FC_NONE, 6'd0);
    step(1, "n_settle", SETTLE, FC_NONE, 6'd10);
    step(3, "n_set3",   SETTLE, FC_NONE, 6'd10);
    step(1, "n_ready",  READY,  FC_NONE, 6'd10);

    // Loss in READY, then osc_en toggles are ignored in FAULT
    dly_q = 1'b0;
    step(2, "l_ready",  READY,  FC_NONE, 6'd10);
    step(1, "l_fault",  FAULT,  FC_LOST, 6'd10);
    osc_en = 1'b0;
    step(1, "l_en0",    FAULT,  FC_LOST, 6'd10);
    osc_en = 1'b1;
    step(1, "l_en1",    FAULT,  FC_LOST, 6'd10);
    osc_en = 1'b0; fault_clr = 1'b1;
    step(1, "l_clr",    IDLE,   FC_NONE, 6'd10);
    fault_clr = 1'b0;
    step(1, "l_idle",   IDLE,   FC_NONE, 6'd10);

    // Timeout, with a stray fault_clr in WAIT
    osc_en = 1'b1;
    step(1, "t_arm0",   ARM,    FC_NONE, 6'd10);
    step(1, "t_arm1",   ARM,    FC_NONE, 6'd10);
    step(1, "t_wait",   WAIT,   FC_NONE, 6'd10);
    fault_clr = 1'b1;
    step(1, "t_clrign", WAIT,   FC_NONE, 6'd10);
    fault_clr = 1'b0;
    step(31, "t_wait32", WAIT,  FC_NONE, 6'd10);
    step(1, "t_fault",  FAULT,  FC_TIMEOUT, 6'd32);
    fault_clr = 1'b1;
    step(1, "t_clr",    IDLE,   FC_NONE, 6'd32);
    fault_clr = 1'b0;
    step(1, "t_rearm",  ARM,    FC_NONE, 6'd32);
    osc_en = 1'b0;
    step(1, "t_idle",   IDLE,   FC_NONE, 6'd32);

    // Early edge at WAIT count 5
    osc_en = 1'b1;
    step(1, "e_arm0",   ARM,    FC_NONE, 6'd32);
    step(1, "e_arm1",   ARM,    FC_NONE, 6'd32);
    step(1, "e_wait",   WAIT,   FC_NONE, 6'd32);
    step(3, "e_wait3",  WAIT,   FC_NONE, 6'd32);
    dly_q = 1'b1;
    step(2, "e_wait5",  WAIT,   FC_NONE, 6'd32);
    step(1, "e_fault",  FAULT,  FC_EARLY, 6'd5);
    osc_en = 1'b0; fault_clr = 1'b1;
    step(1, "e_clr",    IDLE,   FC_NONE, 6'd5);
    fault_clr = 1'b0;

    // Chain stuck high through ARM
    osc_en = 1'b1;
    step(1, "s_arm0",   ARM,    FC_NONE, 6'd5);
    step(1, "s_arm1",   ARM,    FC_NONE, 6'd5);
    step(1, "s_fault",  FAULT,  FC_LOST, 6'd5);
    osc_en = 1'b0; dly_q = 1'b0; fault_clr = 1'b1;
    step(1, "s_clr",    IDLE,   FC_NONE, 6'd5);
    fault_clr = 1'b0;
    step(1, "s_idle",   IDLE,   FC_NONE, 6'd5);

    // Abort at WAIT count 4
    osc_en = 1'b1;
    step(1, "a_arm0",   ARM,    FC_NONE, 6'd5);
    step(1, "a_arm1",   ARM,    FC_NONE, 6'd5);
    step(1, "a_wait",   WAIT,   FC_NONE, 6'd5);
    step(4, "a_wait4",  WAIT,   FC_NONE, 6'd5);
    osc_en = 1'b0;
    step(1, "a_idle",   IDLE,   FC_NONE, 6'd5);

    // Edge exactly at MIN_DLY, then async reset mid-SETTLE
    osc_en = 1'b1;
    step(1, "r_arm0",   ARM,    FC_NONE, 6'd5);
    step(1, "r_arm1",   ARM,    FC_NONE, 6'd5);
    step(1, "r_wait",   WAIT,   FC_NONE, 6'd5);
    step(6, "r_wait6",  WAIT,   FC_NONE, 6'd5);
    dly_q = 1'b1;
    step(2, "r_wait8",  WAIT,   FC_NONE, 6'd5);
    step(1, "r_settle", SETTLE, FC_NONE, 6'd8);
    step(1, "r_set1",   SETTLE, FC_NONE, 6'd8);
    #2;
    rstb = 1'b0;
    push("r_async", IDLE, FC_NONE, 6'd0);
    #1;
    pop_check();
    #2;
    rstb = 1'b1; osc_en = 1'b0; dly_q = 1'b0;
    step(1, "r_idle",   IDLE,   FC_NONE, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
